// File: rtl/mdu_seq.sv
// Sequential RV32M multiply/divide unit: 1-bit-per-cycle shift-add multiplier and restoring divider.
// The divide datapath is compiled in only when macro MDU_DIV_EN is defined.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            illegal
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIN  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]     mplier_q, mplier_d;
  logic                bsgn_q, bsgn_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic                illegal_q, illegal_d;
  logic                busy_q, done_q;

  logic                last_s;
  logic [2*XLEN-1:0]   mul_add_s;
  logic [2*XLEN-1:0]   prod_nxt_s;

`ifdef MDU_DIV_EN
  logic [XLEN-1:0]     rem_q, rem_d;
  logic [XLEN-1:0]     quot_q, quot_d;
  logic [XLEN-1:0]     dvs_q, dvs_d;
  logic                negq_q, negq_d;
  logic                negr_q, negr_d;
  logic                dz_q, dz_d;
  logic [XLEN:0]       div_tmp_s;
  logic                div_ge_s;
  logic [XLEN-1:0]     rem_nxt_s;
  logic [XLEN-1:0]     quot_nxt_s;
`endif

  // Per-iteration datapath: one partial product or one quotient bit per cycle
  always_comb begin
    last_s    = (cnt_q == CW'(XLEN-1));
    mul_add_s = mplier_q[0] ? mcand_q : {(2*XLEN){1'b0}};
    // A signed multiplier's top bit carries negative weight
    if (last_s && bsgn_q) begin
      prod_nxt_s = prod_q - mul_add_s;
    end else begin
      prod_nxt_s = prod_q + mul_add_s;
    end
`ifdef MDU_DIV_EN
    div_tmp_s  = {rem_q, quot_q[XLEN-1]};
    div_ge_s   = (div_tmp_s >= {1'b0, dvs_q});
    rem_nxt_s  = div_ge_s ? (div_tmp_s[XLEN-1:0] - dvs_q) : div_tmp_s[XLEN-1:0];
    quot_nxt_s = {quot_q[XLEN-2:0], div_ge_s};
`endif
  end

  // Next-state and datapath register update
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    prod_d    = prod_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    bsgn_d    = bsgn_q;
    result_d  = result_q;
    illegal_d = illegal_q;
`ifdef MDU_DIV_EN
    rem_d     = rem_q;
    quot_d    = quot_q;
    dvs_d     = dvs_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    dz_d      = dz_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d  = funct3[1:0];
          cnt_d = {CW{1'b0}};
          if (!funct3[2]) begin
            state_d  = S_MUL;
            prod_d   = {(2*XLEN){1'b0}};
            mcand_d  = {{XLEN{(funct3[1] ^ funct3[0]) & rs1[XLEN-1]}}, rs1};
            mplier_d = rs2;
            bsgn_d   = (funct3[1:0] == 2'b01);
          end else begin
`ifdef MDU_DIV_EN
            state_d = S_DIV;
            rem_d   = {XLEN{1'b0}};
            quot_d  = (rs1[XLEN-1] & ~funct3[0]) ? ({XLEN{1'b0}} - rs1) : rs1;
            dvs_d   = (rs2[XLEN-1] & ~funct3[0]) ? ({XLEN{1'b0}} - rs2) : rs2;
            negq_d  = (rs1[XLEN-1] ^ rs2[XLEN-1]) & ~funct3[0];
            negr_d  = rs1[XLEN-1] & ~funct3[0];
            dz_d    = (rs2 == {XLEN{1'b0}});
`else
            state_d   = S_FIN;
            result_d  = {XLEN{1'b0}};
            illegal_d = 1'b1;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        prod_d   = prod_nxt_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (last_s) begin
          state_d   = S_FIN;
          cnt_d     = {CW{1'b0}};
          illegal_d = 1'b0;
          result_d  = (op_q == 2'b00) ? prod_nxt_s[XLEN-1:0] : prod_nxt_s[2*XLEN-1:XLEN];
        end else begin
          state_d = S_MUL;
        end
      end
`ifdef MDU_DIV_EN
      S_DIV: begin
        rem_d  = rem_nxt_s;
        quot_d = quot_nxt_s;
        cnt_d  = cnt_q + CW'(1);
        if (last_s) begin
          state_d   = S_FIN;
          cnt_d     = {CW{1'b0}};
          illegal_d = 1'b0;
          // Divide-by-zero remainder is |rs1| re-signed, i.e. rs1 itself; only the quotient needs a bypass
          if (op_q[1]) begin
            result_d = negr_q ? ({XLEN{1'b0}} - rem_nxt_s) : rem_nxt_s;
          end else if (dz_q) begin
            result_d = {XLEN{1'b1}};
          end else begin
            result_d = negq_q ? ({XLEN{1'b0}} - quot_nxt_s) : quot_nxt_s;
          end
        end else begin
          state_d = S_DIV;
        end
      end
`endif
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 2'b00;
      prod_q    <= {(2*XLEN){1'b0}};
      mcand_q   <= {(2*XLEN){1'b0}};
      mplier_q  <= {XLEN{1'b0}};
      bsgn_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef MDU_DIV_EN
      rem_q     <= {XLEN{1'b0}};
      quot_q    <= {XLEN{1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      negq_q    <= 1'b0;
      negr_q    <= 1'b0;
      dz_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      prod_q    <= prod_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      bsgn_q    <= bsgn_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_FIN);
`ifdef MDU_DIV_EN
      rem_q     <= rem_d;
      quot_q    <= quot_d;
      dvs_q     <= dvs_d;
      negq_q    <= negq_d;
      negr_q    <= negr_d;
      dz_q      <= dz_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign illegal = illegal_q;

endmodule

// File: doc/mdu_seq.md
MDU_SEQ -- requirements
Module: mdu_seq

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width (legal: 8..64, even).
REQ-002 SHALL have clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have start  input  1  request; sampled only while busy=0.
REQ-005 SHALL have funct3  input  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 SHALL have rs1  input  XLEN  operand A (dividend / multiplicand).
REQ-007 SHALL have rs2  input  XLEN  operand B (divisor / multiplier).
REQ-008 SHALL have busy  output  1  operation in progress.
REQ-009 SHALL have done  output  1  one-cycle pulse, result valid.
REQ-010 SHALL have result  output  XLEN  result, held until the next accepted start.
REQ-011 SHALL have illegal  output  1  set with done when the op is not compiled in; held like result.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIN; IDLE->MUL (funct3[2]=0) or IDLE->DIV (funct3[2]=1) on accepted start; MUL/DIV->FIN when the iteration counter reaches XLEN-1; FIN->IDLE unconditionally.
REQ-013 SHALL accept start only in IDLE; funct3, rs1 and rs2 are registered on the accepting edge and are not sampled again.
REQ-014 SHALL ignore start while busy=1, without error or queuing.
REQ-015 SHALL hold busy=1 from the cycle after acceptance through the FIN cycle inclusive.
REQ-016 SHALL assert done for exactly one cycle in FIN, XLEN+1 cycles after the accepting edge, for every op including the special cases.
REQ-017 SHALL, for MUL ops, use a shift-add iteration processing 1 multiplier bit per cycle over XLEN cycles on a 2*XLEN product; signedness: MULH s*s, MULHSU s*u, MULHU u*u.
REQ-018 SHALL return product[XLEN-1:0] for MUL and product[2*XLEN-1:XLEN] for MULH/MULHSU/MULHU.
REQ-019 SHALL, for DIV ops, use restoring division on magnitudes over XLEN cycles; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1) (signed ops only).
REQ-020 SHALL, on divide-by-zero, return quotient all-ones (DIV and DIVU) and remainder = rs1 (REM and REMU).
REQ-021 SHALL, on signed overflow (rs1 = most-negative, rs2 = -1), return quotient = rs1 and remainder = 0 for DIV and REM.
REQ-022 SHALL keep special cases (REQ-020, REQ-021) at the REQ-016 latency.
REQ-023 SHALL allow a new start in the cycle after FIN (back-to-back throughput: one op per XLEN+2 cycles).
REQ-024 SHALL hold illegal=0 for every op compiled in.

Reset
REQ-025 SHALL, with rst=1 at a clock edge, force state IDLE, busy=0, done=0, illegal=0, result=0, counter=0.
REQ-026 SHALL, on reset mid-operation, abort the operation, emit no done, and accept start on the first cycle after rst deasserts.
REQ-027 SHALL give rst priority over a simultaneous start.

Configuration
REQ-028 SHALL compile the divide datapath only when macro MDU_DIV_EN is defined.
REQ-029 SHALL, with MDU_DIV_EN defined, implement all eight ops per REQ-019 to REQ-022.
REQ-030 SHALL, without MDU_DIV_EN, instantiate no divider logic and route funct3[2]=1 through IDLE->FIN directly: done on the 2nd cycle after acceptance, result=0, illegal=1.

Verification
REQ-031 SHALL cover: XLEN=32, MUL with rs1=0xFFFFFFFF, rs2=0x00000002 -> done at cycle 33 after accept, result=0xFFFFFFFE.
REQ-032 SHALL cover: MULH with rs1=0x80000000, rs2=0x80000000 -> result=0x40000000; same operands with MULHU -> result=0x40000000, and MULHSU -> result=0xC0000000.
REQ-033 SHALL cover: DIV with rs1=-7, rs2=2 -> result=0xFFFFFFFD; REM with rs1=-7, rs2=2 -> result=0xFFFFFFFF.
REQ-034 SHALL cover: DIVU with rs2=0 -> result=0xFFFFFFFF; REM with rs1=0x80000000, rs2=0xFFFFFFFF -> result=0, with done at the same latency as normal ops.
REQ-035 SHALL cover: start pulsed at cycles 5 and 10 -> only the first is accepted; rst at cycle 15 -> busy=0 at 16, no done; new start at 16 is accepted.
REQ-036 SHALL cover: without MDU_DIV_EN, DIV start -> done 2 cycles after accept, illegal=1, result=0; a following MUL -> illegal=0.
